qsys_serial_link_master: RTL

- Upstream partner of the Qsys serial host; sits on the controller side of the serial link and shares clk with the host.
- Accepts one parallel read/write command at a time and serialises it into a 65-bit frame on sle/sdi.
- Collects the 32-bit response shifted back on sdo while srdy is high, then returns readdata and status on a local response port.

---
 rtl/qsys_serial_pkg.sv | 35 +++
 rtl/qsys_serial_link_master_shifter.sv | 49 ++++
 rtl/qsys_serial_link_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/qsys_serial_pkg.sv
// Protocol constants and state encoding shared by both ends of the Qsys serial link.
package qsys_serial_pkg;

  localparam int FRAME_BITS = 65;
  localparam int RSP_BITS   = 32;
  localparam int WR_BIT     = 64;
  localparam int ADDR_MSB   = 63;
  localparam int ADDR_LSB   = 32;

  // Frame bit counter (0..64) and response bit counter (0..32, saturating)
  localparam int CNT_W  = 7;
  localparam int RCNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_RSP,
    CAPTURE,
    DONE,
    GAP
  } state_t;

  // Assemble a command frame; the payload field is forced to zero for reads.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic        wr,
                                                        input logic [31:0] addr,
                                                        input logic [31:0] wdata);
    logic [FRAME_BITS-1:0] f;
    f                     = '0;
    f[WR_BIT]             = wr;
    f[ADDR_MSB:ADDR_LSB]  = addr;
    f[RSP_BITS-1:0]       = wr ? wdata : 32'h0;
    return f;
  endfunction

endpackage

// File: rtl/qsys_serial_link_master_shifter.sv
// Frame serialiser (parallel load, MSB-first serial out) and response deserialiser
// (serial in, LSB side) with a saturating received-bit counter.
module qsys_serial_shifter
  import qsys_serial_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  shift_out,
  input  logic                  shift_in,
  input  logic                  sdo,
  output logic                  sdi,
  output logic [RSP_BITS-1:0]   shreg,
  output logic [RCNT_W-1:0]     bit_count
);

  logic [FRAME_BITS-1:0] out_reg;

  // Outgoing frame register; zero fill means sdi is already low once the last bit has left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
    end else if (load) begin
      out_reg <= frame;
    end else if (shift_out) begin
      out_reg <= {out_reg[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign sdi = out_reg[FRAME_BITS-1];

  // Response capture; a long window keeps only the most recent word, the count stops at one word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bit_count <= '0;
    end else if (load) begin
      shreg     <= '0;
      bit_count <= '0;
    end else if (shift_in) begin
      shreg <= {shreg[RSP_BITS-2:0], sdo};
      if (bit_count != RCNT_W'(RSP_BITS)) begin
        bit_count <= bit_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qsys_serial_link_master.sv
// Controller-side master of the Qsys serial link: serialises one read/write command
// into a 65-bit frame, then collects the host's srdy-qualified response word.
module qsys_serial_link_master
  import qsys_serial_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  output logic              sle,
  output logic              sdi,
  input  logic              sdo,
  input  logic              srdy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_readdata,
  output logic              rsp_timeout,
  output logic              rsp_short,
  output logic              busy
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  accept;
  logic                  shift_out;
  logic                  shift_in;
  logic [FRAME_BITS-1:0] frame;
  logic [RSP_BITS-1:0]   shreg;
  logic [RCNT_W-1:0]     rx_count;

  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign frame     = build_frame(cmd_write, 32'(cmd_address), cmd_writedata);
  assign shift_out = (state == SHIFT);
  // srdy during SHIFT is a host protocol error and is deliberately not sampled
  assign shift_in  = ((state == WAIT_RSP) || (state == CAPTURE)) && srdy;

  qsys_serial_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .frame     (frame),
    .shift_out (shift_out),
    .shift_in  (shift_in),
    .sdo       (sdo),
    .sdi       (sdi),
    .shreg     (shreg),
    .bit_count (rx_count)
  );

  // Command FSM with registered handshake, frame enable, timeout and response flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      sle          <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_readdata <= '0;
      rsp_timeout  <= 1'b0;
      rsp_short    <= 1'b0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SHIFT;
            sle       <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            state  <= WAIT_RSP;
            sle    <= 1'b0;
            to_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_RSP: begin
          // srdy takes priority over a timeout expiring in the same cycle
          if (srdy) begin
            state <= CAPTURE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state        <= DONE;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_short    <= 1'b0;
            rsp_readdata <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (!srdy) begin
            state        <= DONE;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= 1'b0;
            rsp_short    <= (rx_count < RCNT_W'(RSP_BITS));
            rsp_readdata <= shreg;
          end
        end
        DONE: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
